// File: rtl/poly_decompress_pkg.sv
// Shared Kyber constants and a legality check for the compressed field width.
package poly_decompress_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEFF_W = 12;
    localparam int IDX_W   = 8;

    function automatic bit legal_d(input int d);
        return (d == 1) || (d == 4) || (d == 5) || (d == 10) || (d == 11);
    endfunction

endpackage

// File: rtl/poly_decompress_if.sv
// Byte-in / coefficient-out stream bundle for the decompressor.
interface poly_decompress_if;
    import poly_decompress_pkg::*;

    logic [7:0]         in_byte;
    logic               in_valid;
    logic               in_ready;
    logic [COEFF_W-1:0] out_coeff;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_coeff, out_idx, out_last, out_valid
    );

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_coeff, out_idx, out_last, out_valid
    );

endinterface

// File: rtl/poly_decompress_core.sv
// Field to coefficient map round(Q*x / 2^D), the inverse of compress.
// Latency: combinational. Backpressure: none, pure function.
// The full 12+D bit product is kept so the rounding shift sees every bit.
module decompress_core #(
    parameter int D = 10,
    parameter int Q = 3329
) (
    input  logic [D-1:0] field,
    output logic [11:0]  coeff
);
    localparam int PW = 12 + D;
    localparam logic [PW-1:0] QW  = PW'(Q);
    localparam logic [PW-1:0] RND = PW'(1) << (D - 1);

    assign coeff = 12'((PW'(field) * QW + RND) >> D);

endmodule

// File: rtl/poly_decompress.sv
// Kyber ByteDecode_D + Decompress_D: bytes in, 12-bit coefficients out in polynomial order.
// Latency: one cycle from the byte completing a field to out_valid.
// Backpressure: out_ready low stalls takes; in_ready drops once more than 2*D bits are buffered.
module poly_decompress
    import poly_decompress_pkg::*;
#(
    parameter int D = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    poly_decompress_if.slave bus
);
    localparam int BW = 2 * D + 8;
    localparam int CW = $clog2(BW + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KYBER_N - 1);

    if (!legal_d(D)) begin : g_bad_d
        $error("poly_decompress: illegal compressed width D");
    end

    logic [BW-1:0]      bit_buf;
    logic [CW-1:0]      bit_cnt;
    logic [IDX_W-1:0]   idx_cnt;
    logic [COEFF_W-1:0] coeff_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_q;
    logic               valid_q;

    logic               accept;
    logic               take;
    logic [BW-1:0]      buf_next;
    logic [CW-1:0]      base;
    logic [CW-1:0]      cnt_next;
    logic [COEFF_W-1:0] coeff;

    // in_ready depends only on bit_cnt, so no combinational path from either side
    assign bus.in_ready  = (bit_cnt <= CW'(2 * D));
    assign accept        = bus.in_valid && bus.in_ready;
    assign take          = (bit_cnt >= CW'(D)) && (!valid_q || bus.out_ready);

    assign bus.out_coeff = coeff_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;

    decompress_core #(
        .D (D),
        .Q (KYBER_Q)
    ) u_core (
        .field (bit_buf[D-1:0]),
        .coeff (coeff)
    );

    // Bits above bit_cnt are always zero, so a new byte can be OR-ed in place.
    always_comb begin
        buf_next = take ? (bit_buf >> D) : bit_buf;
        base     = take ? (bit_cnt - CW'(D)) : bit_cnt;
        cnt_next = base;
        if (accept) begin
            buf_next = buf_next | (BW'(bus.in_byte) << base);
            cnt_next = base + CW'(8);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf <= '0;
            bit_cnt <= '0;
            idx_cnt <= '0;
            coeff_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            bit_buf <= buf_next;
            bit_cnt <= cnt_next;
            if (take) begin
                coeff_q <= coeff;
                idx_q   <= idx_cnt;
                last_q  <= (idx_cnt == IDX_LAST);
                valid_q <= 1'b1;
                idx_cnt <= (idx_cnt == IDX_LAST) ? '0 : idx_cnt + 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_poly_decompress.sv
// Randomized bench for poly_decompress at D=1,4,10,11 plus an exhaustive decompress_core sweep.
module tb_poly_decompress;

    logic clk;
    logic rst_n;

    logic [7:0]  ib_a   [4];
    logic        iv_a   [4];
    logic        ordy_a [4];
    logic        ir_a   [4];
    logic        ov_a   [4];
    logic        ol_a   [4];
    logic [11:0] oc_a   [4];
    logic [7:0]  oi_a   [4];

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    bit rnd_ready  = 0;
    int stall_cnt  = 0;
    bit saw_ir_low = 0;

    bit bitq  [$];
    int exp_c [$];
    int exp_i [$];
    int midx  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 10 : 11;
        poly_decompress_if bus ();
        assign bus.in_byte   = ib_a[g];
        assign bus.in_valid  = iv_a[g];
        assign bus.out_ready = ordy_a[g];
        assign ir_a[g] = bus.in_ready;
        assign ov_a[g] = bus.out_valid;
        assign ol_a[g] = bus.out_last;
        assign oc_a[g] = bus.out_coeff;
        assign oi_a[g] = bus.out_idx;
        poly_decompress #(.D(DG)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    logic [0:0]  f1;
    logic [3:0]  f4;
    logic [4:0]  f5;
    logic [9:0]  f10;
    logic [10:0] f11;
    logic [11:0] c1, c4, c5, c10, c11;

    decompress_core #(.D(1),  .Q(3329)) u_c1  (.field(f1),  .coeff(c1));
    decompress_core #(.D(4),  .Q(3329)) u_c4  (.field(f4),  .coeff(c4));
    decompress_core #(.D(5),  .Q(3329)) u_c5  (.field(f5),  .coeff(c5));
    decompress_core #(.D(10), .Q(3329)) u_c10 (.field(f10), .coeff(c10));
    decompress_core #(.D(11), .Q(3329)) u_c11 (.field(f11), .coeff(c11));

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int dk(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 10 : 11;
    endfunction

    // Kyber Decompress: nearest integer to Q*x/2^d, halves rounded up
    function automatic int ref_coeff(input int d, input int x);
        real r;
        r = 3329.0 * real'(x) / real'(1 << d);
        return int'($floor(r + 0.5));
    endfunction

    task automatic model_push(input int k, input logic [7:0] b);
        int d;
        int f;
        d = dk(k);
        for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
        while (bitq.size() >= d) begin
            f = 0;
            for (int i = 0; i < d; i++) f = f | (int'(bitq.pop_front()) << i);
            exp_c.push_back(ref_coeff(d, f));
            exp_i.push_back(midx[k]);
            midx[k] = (midx[k] + 1) % 256;
        end
    endtask

    task automatic model_clear();
        bitq.delete();
        exp_c.delete();
        exp_i.delete();
        for (int i = 0; i < 4; i++) midx[i] = 0;
    endtask

    // One clock of DUT k: sample at negedge, advance model, update out_ready after posedge.
    task automatic cyc(input int k, output bit acc);
        @(negedge clk);
        acc = iv_a[k] && ir_a[k];
        if (stall_cnt > 0) begin
            if (!ir_a[k]) saw_ir_low = 1;
            if (ov_a[k] && exp_c.size() > 0) begin
                chk("hold_coeff", oc_a[k], exp_c[0]);
                chk("hold_idx", oi_a[k], exp_i[0]);
            end
        end else if (ov_a[k] && ordy_a[k]) begin
            n_out++;
            if (exp_c.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                chk("out_coeff", oc_a[k], exp_c[0]);
                chk("out_idx", oi_a[k], exp_i[0]);
                chk("out_last", ol_a[k], (exp_i[0] == 255) ? 1 : 0);
                void'(exp_c.pop_front());
                void'(exp_i.pop_front());
            end
        end
        if (acc) model_push(k, ib_a[k]);
        @(posedge clk);
        #1;
        if (stall_cnt > 0) stall_cnt--;
        if (stall_cnt > 0) ordy_a[k] = 1'b0;
        else if (rnd_ready) ordy_a[k] = 1'($urandom % 2);
        else ordy_a[k] = 1'b1;
    endtask

    task automatic send(input int k, input logic [7:0] b);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        ib_a[k] = b;
        iv_a[k] = 1'b1;
        while (!acc && n < 1000) begin
            cyc(k, acc);
            n++;
        end
        iv_a[k] = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input int k, output int n);
        bit a;
        n = 0;
        while (exp_c.size() > 0 && n < 3000) begin
            cyc(k, a);
            n++;
        end
        chk("drain_left", exp_c.size(), 0);
    endtask

    initial begin
        int n;
        bit a;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ib_a[i] = '0;
            iv_a[i] = 1'b0;
            ordy_a[i] = 1'b1;
        end
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) begin
            chk("rst_out_valid", ov_a[k], 0);
            chk("rst_out_coeff", oc_a[k], 0);
            chk("rst_out_idx", oi_a[k], 0);
            chk("rst_out_last", ol_a[k], 0);
            chk("rst_in_ready", ir_a[k], 1);
        end

        // decompress_core exhaustive sweep for every legal D
        for (int x = 0; x < 2048; x++) begin
            f1 = 1'(x); f4 = 4'(x); f5 = 5'(x); f10 = 10'(x); f11 = 11'(x);
            #1;
            if (x < 2)    chk("core_d1", c1, ref_coeff(1, x));
            if (x < 16)   chk("core_d4", c4, ref_coeff(4, x));
            if (x < 32)   chk("core_d5", c5, ref_coeff(5, x));
            if (x < 1024) chk("core_d10", c10, ref_coeff(10, x));
            chk("core_d11", c11, ref_coeff(11, x));
            chk("core_lt_q", (c1 < 3329 && c4 < 3329 && c5 < 3329 && c10 < 3329 && c11 < 3329) ? 1 : 0, 1);
        end
        @(posedge clk);
        #1;

        // D=10 directed stream with first-output latency
        send(2, 8'h01);
        send(2, 8'hFC);
        chk("d10_valid_after_byte2", ov_a[2], 0);
        send(2, 8'h0F);
        chk("d10_valid_next_cycle", ov_a[2], 1);
        send(2, 8'h00);
        send(2, 8'h80);
        drain(2, n);

        // D=1: one coefficient per cycle, in_ready low while bits pending
        send(0, 8'hA5);
        chk("d1_in_ready_low", ir_a[0], 0);
        drain(0, n);
        chk("d1_drain_cycles", n, 9);
        chk("d1_in_ready_back", ir_a[0], 1);

        // D=4
        send(1, 8'hF8);
        drain(1, n);

        // D=11: two back-to-back polynomials with random out_ready
        rnd_ready = 1;
        n_out = 0;
        for (int i = 0; i < 704; i++) send(3, 8'($urandom));
        drain(3, n);
        rnd_ready = 0;
        ordy_a[3] = 1'b1;
        repeat (3) cyc(3, a);
        chk("d11_out_count", n_out, 512);
        chk("d11_idle_valid", ov_a[3], 0);
        chk("d11_idle_in_ready", ir_a[3], 1);

        // Backpressure: 20 cycles of out_ready low mid-stream
        for (int i = 0; i < 10; i++) send(2, 8'($urandom));
        stall_cnt = 20;
        ordy_a[2] = 1'b0;
        saw_ir_low = 0;
        for (int i = 0; i < 30; i++) send(2, 8'($urandom));
        drain(2, n);
        chk("bp_in_ready_dropped", saw_ir_low, 1);

        // Async reset mid-polynomial with an output pending
        stall_cnt = 1000;
        ordy_a[2] = 1'b0;
        for (int i = 0; i < 3; i++) send(2, 8'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", ov_a[2], 0);
        chk("arst_out_coeff", oc_a[2], 0);
        chk("arst_out_idx", oi_a[2], 0);
        chk("arst_out_last", ol_a[2], 0);
        chk("arst_in_ready", ir_a[2], 1);
        model_clear();
        stall_cnt = 0;
        ordy_a[2] = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) send(2, 8'($urandom));
        drain(2, n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
